// File: rtl/key_scan_ctrl_pkg.sv
// rtl/key_scan_ctrl_pkg.sv - shared constants, debounce states and key helpers
package key_pkg;

    localparam int KEY_N  = 20;
    localparam int CODE_W = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COMMIT = 2'd2
    } deb_state_t;

    // Index of the lowest set bit; lower keys win when several are pending.
    function automatic logic [CODE_W-1:0] lowest_idx(input logic [KEY_N-1:0] v);
        lowest_idx = '0;
        for (int i = KEY_N - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = CODE_W'(i);
        end
    endfunction

endpackage

// File: rtl/key_scan_ctrl_if.sv
// rtl/key_scan_ctrl_if.sv - key event handshake between controller and consumer
interface key_scan_ctrl_if;
    import key_pkg::*;

    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_ready;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);

endinterface

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - first-word fall-through event queue for key codes
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_valid,
    output logic                     o_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Fullness is judged on the pre-pop count, so a pop never makes room in the same cycle.
    assign o_valid   = (r_count != '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && o_valid;
    assign o_head    = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count   = r_count;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        next_ptr = (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/key_scan_ctrl.sv
// rtl/key_scan_ctrl.sv - key matrix debouncer that queues one event per new press
module key_scan_ctrl
    import key_pkg::*;
#(
    parameter int DIV    = 50000,
    parameter int STABLE = 4,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEY_N-1:0]       raw_keys,
    output logic [KEY_N-1:0]       key_state,
    key_scan_ctrl_if.master        evt,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    input  logic                   ovf_clr
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0]     r_presc;
    logic [KEY_N-1:0]  r_sample;
    logic [3:0]        r_stable_cnt;
    deb_state_t        r_state;
    logic [KEY_N-1:0]  r_key_state;
    logic [KEY_N-1:0]  r_pending;
    logic              r_overflow;

    logic              w_tick;
    logic [3:0]        w_settle_cnt;
    logic [KEY_N-1:0]  w_press;
    logic              w_commit;
    logic              w_full;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic [CODE_W-1:0] w_push_code;
    logic [CODE_W-1:0] w_head;
    logic [KEY_N-1:0]  w_push_mask;
    logic [KEY_N-1:0]  w_pending_left;
    logic              w_ovf_set;

    assign w_tick       = (r_presc == PW'(DIV - 1));
    assign w_settle_cnt = (raw_keys == r_sample) ? r_stable_cnt + 4'd1 : 4'd1;
    assign w_commit     = (r_state == S_COMMIT);
    assign w_press      = r_sample & ~r_key_state;

    assign w_push         = (r_pending != '0) && !w_full;
    assign w_push_code    = lowest_idx(r_pending);
    assign w_push_mask    = w_push ? (KEY_N'(1) << w_push_code) : '0;
    assign w_pending_left = r_pending & ~w_push_mask;
    // A press is lost only if its earlier event is still waiting after this cycle's push.
    assign w_ovf_set      = w_commit && ((w_press & w_pending_left) != '0);
    assign w_pop          = w_valid && evt.key_ready;

    assign key_state     = r_key_state;
    assign overflow      = r_overflow;
    assign evt.key_valid = w_valid;
    assign evt.key_code  = w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_presc <= '0;
        else        r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sample     <= '0;
            r_stable_cnt <= '0;
            r_key_state  <= '0;
        end else begin
            if (w_tick) r_sample <= raw_keys;
            case (r_state)
                S_IDLE: begin
                    if (w_tick && (raw_keys != r_key_state)) begin
                        r_stable_cnt <= 4'd1;
                        r_state      <= (STABLE == 1) ? S_COMMIT : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_tick) begin
                        if (raw_keys == r_key_state) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_stable_cnt <= w_settle_cnt;
                            if (w_settle_cnt == 4'(STABLE)) r_state <= S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    r_key_state <= r_sample;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending <= w_pending_left | (w_commit ? w_press : '0);
            if (w_ovf_set)    r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
        end
    end

    key_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_code),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (fifo_count),
        .o_valid (w_valid),
        .o_full  (w_full)
    );

endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb/tb_key_scan_ctrl.sv - randomized and directed bench with a behavioural key-event model
module tb_key_scan_ctrl;
    import key_pkg::*;

    localparam int DIV    = 4;
    localparam int STABLE = 3;
    localparam int DEPTH  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [KEY_N-1:0] raw_keys = '0;
    logic [KEY_N-1:0] key_state;
    logic [2:0]       fifo_count;
    logic             overflow;
    logic             ovf_clr = 1'b0;

    key_scan_ctrl_if bif ();

    key_scan_ctrl #(.DIV(DIV), .STABLE(STABLE), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_keys   (raw_keys),
        .key_state  (key_state),
        .evt        (bif),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [KEY_N-1:0] m_keys, m_sample, m_pending;
    bit               m_settling, m_commit, m_ovf;
    int               m_run, m_cyc;
    int               m_q[$];
    int               got_q[$];
    int               exp_q[$];
    int               valid_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("key_state", 32'(key_state), 32'(m_keys));
        check("key_valid", 32'(bif.key_valid), 32'(m_q.size() != 0));
        check("key_code", 32'(bif.key_code), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        raw_keys = '0;
        bif.key_ready = 1'b0;
        ovf_clr = 1'b0;
        m_keys = '0; m_sample = '0; m_pending = '0;
        m_settling = 0; m_commit = 0; m_ovf = 0;
        m_run = 0; m_cyc = 0;
        m_q.delete();
        #1;
        check_outputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        got_q.delete();
        valid_cycles = 0;
    endtask

    // One clock: apply inputs, advance the model, then compare after the edge.
    task automatic step(input logic [KEY_N-1:0] raw, input bit rdy, input bit clr);
        logic [KEY_N-1:0] press;
        int  code;
        bit  tick, push, pop, commit_now, ovf_set;
        raw_keys = raw;
        bif.key_ready = rdy;
        ovf_clr = clr;
        if (bif.key_valid) valid_cycles++;
        if (bif.key_valid && rdy) got_q.push_back(int'(bif.key_code));

        tick = ((m_cyc % DIV) == DIV - 1);
        pop  = (m_q.size() != 0) && rdy;
        push = (m_pending != 0) && (m_q.size() < DEPTH);
        code = 0;
        if (push) begin
            for (int i = 0; i < KEY_N; i++) begin
                if (m_pending[i]) begin
                    code = i;
                    break;
                end
            end
            m_pending[code] = 1'b0;
        end

        commit_now = m_commit;
        m_commit = 0;
        ovf_set = 0;
        if (commit_now) begin
            press = m_sample & ~m_keys;
            ovf_set = ((press & m_pending) != 0);
            m_pending = m_pending | press;
            m_keys = m_sample;
        end
        if (tick) begin
            if (!m_settling) begin
                if (raw != m_keys) begin
                    m_settling = 1;
                    m_run = 1;
                end
            end else if (raw == m_keys) begin
                m_settling = 0;
            end else if (raw == m_sample) begin
                m_run++;
            end else begin
                m_run = 1;
            end
            if (m_settling && m_run == STABLE) begin
                m_commit = 1;
                m_settling = 0;
            end
            m_sample = raw;
        end
        if (ovf_set) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(code);
        m_cyc++;

        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic hold(input logic [KEY_N-1:0] v, input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(v, rdy, 1'b0);
    endtask

    task automatic press_release(input int key, input bit rdy);
        hold(KEY_N'(1) << key, rdy, 16);
        hold('0, rdy, 16);
    endtask

    task automatic expect_events(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check({tag, "_code"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #2;
        do_reset();

        // Single steady press
        hold(20'h00001, 1'b1, 30);
        check("single_state", 32'(key_state), 32'h1);
        check("single_valid_cycles", 32'(valid_cycles), 32'd1);
        exp_q = {0};
        expect_events("single");

        // Bouncing key settles into one event
        do_reset();
        for (int t = 0; t < 5; t++) hold((t % 2 == 0) ? 20'h00004 : 20'h0, 1'b1, 4);
        check("bounce_no_commit", 32'(key_state), 32'h0);
        hold(20'h00004, 1'b1, 24);
        check("bounce_state", 32'(key_state), 32'h4);
        exp_q = {2};
        expect_events("bounce");

        // Simultaneous presses drain lowest first
        do_reset();
        hold(20'h80011, 1'b1, 30);
        check("multi_valid_cycles", 32'(valid_cycles), 32'd3);
        exp_q = {0, 4, 19};
        expect_events("multi");

        // Full FIFO holds remaining presses in pending
        do_reset();
        press_release(3, 1'b0);
        press_release(7, 1'b0);
        press_release(1, 1'b0);
        press_release(12, 1'b0);
        press_release(9, 1'b0);
        press_release(15, 1'b0);
        check("sat_count", 32'(fifo_count), 32'd4);
        check("sat_overflow", 32'(overflow), 32'd0);
        hold('0, 1'b1, 24);
        exp_q = {3, 7, 1, 12, 9, 15};
        expect_events("drain");

        // Repeat press while its first event is still pending
        do_reset();
        for (int k = 0; k < 4; k++) press_release(k, 1'b0);
        press_release(5, 1'b0);
        check("ovf_before", 32'(overflow), 32'd0);
        hold(20'h00020, 1'b0, 16);
        check("ovf_set", 32'(overflow), 32'd1);
        step(20'h00020, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 32'd0);

        // Reset mid-settle with queued events
        do_reset();
        press_release(6, 1'b0);
        press_release(8, 1'b0);
        check("pre_reset_count", 32'(fifo_count), 32'd2);
        hold(20'h00400, 1'b0, 6);
        do_reset();
        hold('0, 1'b1, 40);
        check("post_reset_events", 32'(got_q.size()), 32'd0);
        check("post_reset_valid", 32'(valid_cycles), 32'd0);

        // Randomized stimulus against the model
        do_reset();
        for (int s = 0; s < 150; s++) begin
            logic [KEY_N-1:0] v;
            int dur;
            bit slow;
            v = '0;
            if ($urandom_range(0, 3) != 0) v = KEY_N'(1) << $urandom_range(0, KEY_N - 1);
            if ($urandom_range(0, 4) == 0) v = v | (KEY_N'(1) << $urandom_range(0, KEY_N - 1));
            dur = $urandom_range(1, 24);
            slow = ($urandom_range(0, 2) == 0);
            for (int c = 0; c < dur; c++) begin
                step(v, slow ? 1'b0 : ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
            end
        end
        hold('0, 1'b1, 40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
